// File: rtl/pifo_req_scheduler.sv
// pifo_req_scheduler
// Ingress scheduler in front of the BMW-PIFO task generator. External push
// requests are buffered in a small FIFO. Pushes aimed at the root RPU are
// dropped. At most one push per cycle is issued while the task FIFO has room.
// Pop commands are paced so that a pop only goes out while at least one
// element is resident in the tree.
//
// Ports
//   i_clk, i_arst_n                 clock, async active-low reset
//   i_push_req_valid/o_push_req_ready, i_push_req_tree_id, i_push_req_data
//                                   push request handshake and payload
//   i_pop_req_valid/o_pop_req_ready pop request handshake
//   i_task_fifo_full                backpressure from the task generator
//   o_push, o_push_tree_id, o_push_data   registered push command
//   o_pop                           registered pop command
//   o_occupancy                     elements pushed minus popped
//   o_drop_cnt                      dropped root-RPU pushes
//
// Build option: define PIFO_REQ_SCHED_STATS_EN to build the saturating drop
// counter. Without it, o_drop_cnt is tied to zero and drops still happen.
//
// Pop pacing FSM
//   state    | meaning
//   ST_IDLE  | waiting for a pop request; ready when occupancy > 0
//   ST_ISSUE | o_pop is high for this one cycle
//   ST_GAP   | POP_GAP enforced idle cycles before the next request

module pifo_req_scheduler #(
    parameter int PTW           = 16,
    parameter int MTW           = 0,
    parameter int TREE_NUM      = 4,
    parameter int LEVEL         = 4,
    parameter int IN_DEPTH      = 8,
    parameter int POP_GAP       = 2,
    parameter int OCC_W         = 16,
    parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
    parameter int LEVEL_BITS    = $clog2(LEVEL)
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_push_req_valid,
    output logic                     o_push_req_ready,
    input  logic [TREE_NUM_BITS-1:0] i_push_req_tree_id,
    input  logic [MTW+PTW-1:0]       i_push_req_data,
    input  logic                     i_pop_req_valid,
    output logic                     o_pop_req_ready,
    input  logic                     i_task_fifo_full,
    output logic                     o_push,
    output logic [TREE_NUM_BITS-1:0] o_push_tree_id,
    output logic [MTW+PTW-1:0]       o_push_data,
    output logic                     o_pop,
    output logic [OCC_W-1:0]         o_occupancy,
    output logic [15:0]              o_drop_cnt
);

    localparam int DW = MTW + PTW;
    localparam int EW = TREE_NUM_BITS + DW;
    localparam int AW = $clog2(IN_DEPTH);
    localparam int GW = (POP_GAP > 1) ? $clog2(POP_GAP) : 1;

    localparam logic [GW-1:0]            GAP_LOAD   = GW'(POP_GAP - 1);
    localparam logic [OCC_W-1:0]         OCC_MAX    = '1;
    localparam logic [OCC_W-1:0]         OCC_MAX_M1 = OCC_MAX - 1'b1;
    localparam logic [TREE_NUM_BITS-1:0] LVL_MASK   = TREE_NUM_BITS'((1 << LEVEL_BITS) - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    logic [EW-1:0]            r_mem [IN_DEPTH];
    logic [AW:0]              r_wptr;
    logic [AW:0]              r_rptr;
    logic                     r_push;
    logic [TREE_NUM_BITS-1:0] r_push_tree;
    logic [DW-1:0]            r_push_data;
    logic                     r_pop;
    logic [OCC_W-1:0]         r_occ;
    state_t                   r_state;
    logic [GW-1:0]            r_gap_cnt;

    logic                     w_full;
    logic                     w_empty;
    logic                     w_accept;
    logic                     w_root;
    logic                     w_wr;
    logic                     w_drop;
    logic                     w_occ_room;
    logic                     w_issue;
    logic                     w_pop_ready;
    state_t                   w_state_nxt;
    logic [GW-1:0]            w_gap_nxt;

    // Extra pointer MSB distinguishes full from empty.
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty  = (r_wptr == r_rptr);
    assign w_accept = i_push_req_valid && !w_full;
    assign w_root   = ((i_push_req_tree_id & LVL_MASK) == '0);
    assign w_wr     = w_accept && !w_root;
    assign w_drop   = w_accept && w_root;

    // The push already on o_push has not been counted yet, so it is included
    // when deciding whether another one still fits in the counter.
    assign w_occ_room = (r_occ != OCC_MAX) && !(r_push && (r_occ == OCC_MAX_M1));
    assign w_issue    = !w_empty && !i_task_fifo_full && w_occ_room;

    assign w_pop_ready = (r_state == ST_IDLE) && (r_occ != '0);

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= {i_push_req_tree_id, i_push_req_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_push      <= 1'b0;
            r_push_tree <= '0;
            r_push_data <= '0;
        end else begin
            r_push <= w_issue;
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_issue) begin
                {r_push_tree, r_push_data} <= r_mem[r_rptr[AW-1:0]];
                r_rptr                     <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_occ <= '0;
        end else begin
            case ({r_push, r_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
            r_pop     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_pop     <= (w_state_nxt == ST_ISSUE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_pop_req_valid && w_pop_ready) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_GAP;
                w_gap_nxt   = GAP_LOAD;
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gap_nxt   = '0;
            end
        endcase
    end

`ifdef PIFO_REQ_SCHED_STATS_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`else
    logic w_drop_unused;
    assign w_drop_unused = w_drop;
    assign o_drop_cnt    = 16'd0;
`endif

    assign o_push_req_ready = !w_full;
    assign o_pop_req_ready  = w_pop_ready;
    assign o_push           = r_push;
    assign o_push_tree_id   = r_push_tree;
    assign o_push_data      = r_push_data;
    assign o_pop            = r_pop;
    assign o_occupancy      = r_occ;

endmodule

// File: tb/tb_pifo_req_scheduler.sv
module tb_pifo_req_scheduler;

    localparam int PTW      = 16;
    localparam int MTW      = 0;
    localparam int TREE_NUM = 4;
    localparam int LEVEL    = 4;
    localparam int IN_DEPTH = 8;
    localparam int POP_GAP  = 2;
    localparam int OCC_W    = 16;
    localparam int TNB      = $clog2(TREE_NUM);
    localparam int DW       = MTW + PTW;
    localparam longint OCC_LIM = (longint'(1) << OCC_W) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           push_valid = 1'b0;
    logic           push_ready;
    logic [TNB-1:0] push_tree = '0;
    logic [DW-1:0]  push_data = '0;
    logic           pop_valid = 1'b0;
    logic           pop_ready;
    logic           task_full = 1'b0;
    logic           o_push;
    logic [TNB-1:0] o_push_tree_id;
    logic [DW-1:0]  o_push_data;
    logic           o_pop;
    logic [OCC_W-1:0] o_occupancy;
    logic [15:0]    o_drop_cnt;

    pifo_req_scheduler #(
        .PTW(PTW), .MTW(MTW), .TREE_NUM(TREE_NUM), .LEVEL(LEVEL),
        .IN_DEPTH(IN_DEPTH), .POP_GAP(POP_GAP), .OCC_W(OCC_W)
    ) dut (
        .i_clk              (clk),
        .i_arst_n           (rst_n),
        .i_push_req_valid   (push_valid),
        .o_push_req_ready   (push_ready),
        .i_push_req_tree_id (push_tree),
        .i_push_req_data    (push_data),
        .i_pop_req_valid    (pop_valid),
        .o_pop_req_ready    (pop_ready),
        .i_task_fifo_full   (task_full),
        .o_push             (o_push),
        .o_push_tree_id     (o_push_tree_id),
        .o_push_data        (o_push_data),
        .o_pop              (o_pop),
        .o_occupancy        (o_occupancy),
        .o_drop_cnt         (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [TNB-1:0] tree;
        logic [DW-1:0]  data;
    } exp_t;
    exp_t sb[$];

    // Reference model: FIFO fill level, resident elements, pop pacing.
    int     cnt_q, wr_q, occ_q, last_hs, drops;
    bit     full_q, push_q, pop_q;
    logic [TNB-1:0] last_tree;
    logic [DW-1:0]  last_data;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        cyc = 0; cnt_q = 0; wr_q = 0; occ_q = 0; drops = 0;
        last_hs = -1000;
        full_q = 0; push_q = 0; pop_q = 0;
        last_tree = '0; last_data = '0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            int  cnt, occ, exp_drop;
            bit  e_push, e_pop, e_pready, e_rdy, is_root;
            exp_t e;
            cyc++;
            e_push   = (cnt_q > 0) && !full_q && ((longint'(occ_q) + push_q) < OCC_LIM);
            cnt      = cnt_q + wr_q - int'(e_push);
            occ      = occ_q + int'(push_q) - int'(pop_q);
            e_pop    = (cyc == last_hs + 1);
            e_pready = (occ > 0) && (cyc >= last_hs + 2 + POP_GAP);
            e_rdy    = (cnt < IN_DEPTH);

            chk("o_push", o_push, e_push);
            if (o_push) begin
                if (sb.size() == 0) begin
                    chk("push_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    last_tree = e.tree;
                    last_data = e.data;
                end
            end
            chk("push_tree", o_push_tree_id, last_tree);
            chk("push_data", o_push_data, last_data);
            chk("o_pop", o_pop, e_pop);
            chk("occupancy", o_occupancy, occ);
            chk("push_ready", push_ready, e_rdy);
            chk("pop_ready", pop_ready, e_pready);
`ifdef PIFO_REQ_SCHED_STATS_EN
            exp_drop = (drops > 65535) ? 65535 : drops;
`else
            exp_drop = 0;
`endif
            chk("drop_cnt", o_drop_cnt, exp_drop);

            // Root RPU is any tree whose index is a multiple of LEVEL.
            is_root = ((int'(push_tree) % LEVEL) == 0);
            wr_q = 0;
            if (push_valid && e_rdy) begin
                if (is_root) begin
                    drops++;
                end else begin
                    wr_q = 1;
                    e.tree = push_tree;
                    e.data = push_data;
                    sb.push_back(e);
                end
            end
            if (pop_valid && e_pready) last_hs = cyc;
            cnt_q  = cnt;
            occ_q  = occ;
            full_q = task_full;
            push_q = e_push;
            pop_q  = e_pop;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        push_valid = 1'b0; pop_valid = 1'b0; task_full = 1'b0;
        push_tree = '0; push_data = '0;
        #1;
        chk("rst_push", o_push, 0);
        chk("rst_tree", o_push_tree_id, 0);
        chk("rst_data", o_push_data, 0);
        chk("rst_pop", o_pop, 0);
        chk("rst_occ", o_occupancy, 0);
        chk("rst_drop", o_drop_cnt, 0);
        chk("rst_push_ready", push_ready, 1);
        chk("rst_pop_ready", pop_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push1(input int tree, input int data);
        push_valid = 1'b1;
        push_tree  = TNB'(tree);
        push_data  = DW'(data);
        tick();
        push_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #2;
        do_reset();
        idle(2);

        // Single push: visible two cycles after the handshake.
        push1(1, 16'h00AA);
        idle(4);

        // Fill the ingress FIFO under backpressure, then release.
        task_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push_valid = 1'b1;
            push_tree  = 2'd2;
            push_data  = DW'(16'h0100 + i);
            tick();
        end
        push_valid = 1'b0;
        idle(2);
        task_full = 1'b0;
        idle(12);
        chk("occ_after_burst", o_occupancy, 9);

        // Root-RPU pushes: tree 0 and tree 4 (which aliases to 0 in 2 bits).
        push1(0, 16'h1111);
        push1(4 % TREE_NUM, 16'h2222);
        idle(4);

        // Drain everything.
        pop_valid = 1'b1;
        for (int i = 0; i < 200 && o_occupancy != 0; i++) tick();
        chk("drain", o_occupancy, 0);
        idle(5);
        pop_valid = 1'b0;

        // Pop is only accepted once an element is resident.
        push1(3, 16'h3333);
        idle(3);
        pop_valid = 1'b1;
        idle(8);
        pop_valid = 1'b0;

        // Three elements, pop valid held: pulses spaced by 2+POP_GAP.
        push1(1, 16'h4001);
        push1(2, 16'h4002);
        push1(3, 16'h4003);
        idle(4);
        pop_valid = 1'b1;
        idle(20);
        pop_valid = 1'b0;

        // Push and pop strobes in the same cycle.
        push1(2, 16'h5001);
        idle(4);
        push1(1, 16'h5002);
        pop_valid = 1'b1;
        tick();
        pop_valid = 1'b0;
        idle(6);

        // Reset while in the gap with requests buffered behind backpressure.
        task_full = 1'b1;
        push1(1, 16'h6001);
        push1(2, 16'h6002);
        pop_valid = 1'b1;
        tick();
        pop_valid = 1'b0;
        tick();
        tick();
        do_reset();
        idle(3);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            push_valid = ($urandom_range(0, 1) == 1);
            push_tree  = TNB'($urandom_range(0, TREE_NUM - 1));
            push_data  = DW'($urandom);
            pop_valid  = ($urandom_range(0, 2) != 0);
            task_full  = ($urandom_range(0, 3) == 0);
            tick();
        end
        push_valid = 1'b0;
        pop_valid  = 1'b0;
        task_full  = 1'b0;
        idle(20);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
